// File: rtl/pong_pixel_gen_if.sv
// Pixel-generator bus: timing-stage counters, CPU register writes, colour and status outputs.
interface pong_pixel_gen_if;
    logic [15:0] hcount;
    logic [15:0] vcount;
    logic        vga_blank_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  r_out;
    logic [3:0]  g_out;
    logic [3:0]  b_out;
    logic        frame_done;
    logic        coll_l;
    logic        coll_r;

    modport master (
        output hcount, vcount, vga_blank_n, wr_en, wr_addr, wr_data,
        input  r_out, g_out, b_out, frame_done, coll_l, coll_r
    );

    modport slave (
        input  hcount, vcount, vga_blank_n, wr_en, wr_addr, wr_data,
        output r_out, g_out, b_out, frame_done, coll_l, coll_r
    );
endinterface

// File: rtl/pong_pixel_gen.sv
// Pong pixel source: two paddles and a ball from shadowed CPU registers, committed once per frame.
// Optional dashed centre net enabled by defining PONG_NET_EN.
module pong_pixel_gen (
    input  logic             clk,
    input  logic             rst,
    pong_pixel_gen_if.slave  bus
);
    localparam int unsigned H_START  = 158;
    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned PADDLE_W = 8;
    localparam int unsigned PADDLE_H = 64;
    localparam int unsigned BALL_SZ  = 8;
    localparam int unsigned PADL_X   = 16;
    localparam int unsigned PADR_X   = 596;
    localparam int unsigned SW       = 18;
`ifdef PONG_NET_EN
    localparam int unsigned SCREEN_W = 620;
    localparam int unsigned NET_X    = SCREEN_W / 2 - 1;
`endif

    logic [15:0] sh_padl_y, sh_padr_y, sh_ball_x, sh_ball_y;
    logic [11:0] sh_fg;
    logic [15:0] act_padl_y, act_padr_y, act_ball_x, act_ball_y;
    logic [11:0] act_fg;
    logic        in_disp_q;
    logic        sticky_l, sticky_r;
    logic [11:0] rgb_q;
    logic        frame_done_q, coll_l_q, coll_r_q;

    logic        in_disp_c, commit_c;
    logic        ball_c, padl_c, padr_c, obj_c;
    logic [SW-1:0] hc_c, vc_c;

    // Half-open span test; operands are widened so positions near 16'hFFFF clip instead of wrap.
    function automatic logic span(input logic [SW-1:0] c, input logic [SW-1:0] lo,
                                  input logic [SW-1:0] sz);
        return (c >= lo) && (c < lo + sz);
    endfunction

    always_comb begin
        hc_c      = SW'(bus.hcount);
        vc_c      = SW'(bus.vcount);
        in_disp_c = (bus.vcount < 16'(SCREEN_H));
        commit_c  = in_disp_q && !in_disp_c;
        ball_c    = span(hc_c, SW'(H_START) + SW'(act_ball_x), SW'(BALL_SZ)) &&
                    span(vc_c, SW'(act_ball_y), SW'(BALL_SZ));
        padl_c    = span(hc_c, SW'(H_START + PADL_X), SW'(PADDLE_W)) &&
                    span(vc_c, SW'(act_padl_y), SW'(PADDLE_H));
        padr_c    = span(hc_c, SW'(H_START + PADR_X), SW'(PADDLE_W)) &&
                    span(vc_c, SW'(act_padr_y), SW'(PADDLE_H));
        obj_c     = ball_c || padl_c || padr_c;
`ifdef PONG_NET_EN
        // Net sits below every object; all share the fg colour so only coverage matters.
        if (span(hc_c, SW'(H_START + NET_X), SW'(2)) && !bus.vcount[3]) begin
            obj_c = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_padl_y    <= '0;
            sh_padr_y    <= '0;
            sh_ball_x    <= '0;
            sh_ball_y    <= '0;
            sh_fg        <= 12'hFFF;
            act_padl_y   <= '0;
            act_padr_y   <= '0;
            act_ball_x   <= '0;
            act_ball_y   <= '0;
            act_fg       <= 12'hFFF;
            in_disp_q    <= 1'b1;
            sticky_l     <= 1'b0;
            sticky_r     <= 1'b0;
            rgb_q        <= '0;
            frame_done_q <= 1'b0;
            coll_l_q     <= 1'b0;
            coll_r_q     <= 1'b0;
        end else begin
            in_disp_q    <= in_disp_c;
            frame_done_q <= commit_c;
            rgb_q        <= (bus.vga_blank_n && obj_c) ? act_fg : 12'h000;

            if (commit_c) begin
                coll_l_q   <= sticky_l;
                coll_r_q   <= sticky_r;
                sticky_l   <= 1'b0;
                sticky_r   <= 1'b0;
                act_padl_y <= sh_padl_y;
                act_padr_y <= sh_padr_y;
                act_ball_x <= sh_ball_x;
                act_ball_y <= sh_ball_y;
                act_fg     <= sh_fg;
            end else if (bus.vga_blank_n) begin
                if (ball_c && padl_c) sticky_l <= 1'b1;
                if (ball_c && padr_c) sticky_r <= 1'b1;
            end

            // A write on the commit clock overrides the commit copy so it is visible at once.
            if (bus.wr_en) begin
                case (bus.wr_addr)
                    3'd0: begin
                        sh_padl_y <= bus.wr_data;
                        if (commit_c) act_padl_y <= bus.wr_data;
                    end
                    3'd1: begin
                        sh_padr_y <= bus.wr_data;
                        if (commit_c) act_padr_y <= bus.wr_data;
                    end
                    3'd2: begin
                        sh_ball_x <= bus.wr_data;
                        if (commit_c) act_ball_x <= bus.wr_data;
                    end
                    3'd3: begin
                        sh_ball_y <= bus.wr_data;
                        if (commit_c) act_ball_y <= bus.wr_data;
                    end
                    3'd4: begin
                        sh_fg <= bus.wr_data[11:0];
                        if (commit_c) act_fg <= bus.wr_data[11:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.r_out      = rgb_q[11:8];
    assign bus.g_out      = rgb_q[7:4];
    assign bus.b_out      = rgb_q[3:0];
    assign bus.frame_done = frame_done_q;
    assign bus.coll_l     = coll_l_q;
    assign bus.coll_r     = coll_r_q;
endmodule

// File: tb/tb_pong_pixel_gen.sv
// Bench for pong_pixel_gen: directed vector table, hand sequences and random traffic vs a pixel model.
module tb_pong_pixel_gen;
    localparam int H = 158;

    logic clk;
    logic rst;
    pong_pixel_gen_if bus();

    pong_pixel_gen dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: index 0 padL_y, 1 padR_y, 2 ball_x, 3 ball_y, 4 fg
    logic [15:0] m_sh  [5];
    logic [15:0] m_act [5];
    bit          m_in_q, m_sl, m_sr;
    logic [11:0] exp_rgb;
    bit          exp_fd, exp_cl, exp_cr;

    typedef struct {
        logic [15:0] hc;
        logic [15:0] vc;
        logic        bl;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [11:0] rgb;
        logic        fd;
        logic        cl;
        logic        cr;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = 16'h0;
            m_act[i] = 16'h0;
        end
        m_sh[4]  = 16'h0FFF;
        m_act[4] = 16'h0FFF;
        m_in_q = 1'b1;
        m_sl = 1'b0;
        m_sr = 1'b0;
        exp_rgb = 12'h0;
        exp_fd = 1'b0;
        exp_cl = 1'b0;
        exp_cr = 1'b0;
    endtask

    function automatic bit inside_box(input int px, input int py, input int bx, input int by,
                                      input int w, input int h);
        return (px >= bx) && (px < bx + w) && (py >= by) && (py < by + h);
    endfunction

    // One clock of the reference: uses the inputs present at the edge and pre-edge register values.
    task automatic model_clk();
        int x, v;
        bit in_disp, commit, ball, padl, padr, net;
        logic [15:0] fgw;
        x = int'(bus.hcount) - H;
        v = int'(bus.vcount);
        in_disp = (v < 480);
        commit  = m_in_q && !in_disp;
        ball = inside_box(x, v, int'(m_act[2]), int'(m_act[3]), 8, 8);
        padl = inside_box(x, v, 16, int'(m_act[0]), 8, 64);
        padr = inside_box(x, v, 596, int'(m_act[1]), 8, 64);
`ifdef PONG_NET_EN
        net = (x >= 309) && (x < 311) && ((v % 16) < 8);
`else
        net = 1'b0;
`endif
        fgw = m_act[4];
        exp_rgb = (bus.vga_blank_n && (ball || padl || padr || net)) ? fgw[11:0] : 12'h0;
        exp_fd = commit;
        if (commit) begin
            exp_cl = m_sl;
            exp_cr = m_sr;
            m_sl = 1'b0;
            m_sr = 1'b0;
            for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
        end else if (bus.vga_blank_n) begin
            if (ball && padl) m_sl = 1'b1;
            if (ball && padr) m_sr = 1'b1;
        end
        if (bus.wr_en && bus.wr_addr < 3'd5) begin
            m_sh[bus.wr_addr] = (bus.wr_addr == 3'd4) ? {4'h0, bus.wr_data[11:0]} : bus.wr_data;
            if (commit) m_act[bus.wr_addr] = m_sh[bus.wr_addr];
        end
        m_in_q = in_disp;
    endtask

    task automatic set_in(input logic [15:0] hc, input logic [15:0] vc, input logic bl,
                          input logic we, input logic [2:0] wa, input logic [15:0] wd);
        bus.hcount = hc;
        bus.vcount = vc;
        bus.vga_blank_n = bl;
        bus.wr_en = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_clk();
        #1;
        check({tag, "_rgb"}, 32'({bus.r_out, bus.g_out, bus.b_out}), 32'(exp_rgb));
        check({tag, "_frame_done"}, 32'(bus.frame_done), 32'(exp_fd));
        check({tag, "_coll_l"}, 32'(bus.coll_l), 32'(exp_cl));
        check({tag, "_coll_r"}, 32'(bus.coll_r), 32'(exp_cr));
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        set_in(16'd0, 16'd200, 1'b0, 1'b1, a, d);
        step("wr");
    endtask

    task automatic commit_frame();
        set_in(16'd0, 16'd480, 1'b0, 1'b0, 3'd0, 16'd0);
        step("commit");
        set_in(16'd0, 16'd481, 1'b0, 1'b0, 3'd0, 16'd0);
        step("vblank");
    endtask

    task automatic pixel(input int x, input int y);
        set_in(16'(H + x), 16'(y), 1'b1, 1'b0, 3'd0, 16'd0);
        step("pix");
    endtask

    initial begin
        //            hc          vc    bl  we  wa  wd         rgb      fd  cl  cr
        tbl[0]  = '{16'(H+100), 16'd200, 1, 1, 3'd2, 16'd100,    12'h000, 0, 0, 0};
        tbl[1]  = '{16'(H+100), 16'd200, 1, 1, 3'd3, 16'd50,     12'h000, 0, 0, 0};
        tbl[2]  = '{16'(H+100), 16'd50,  1, 0, 3'd0, 16'd0,      12'h000, 0, 0, 0};
        tbl[3]  = '{16'(H+20),  16'd10,  1, 0, 3'd0, 16'd0,      12'hFFF, 0, 0, 0};
        tbl[4]  = '{16'(H+3),   16'd3,   1, 0, 3'd0, 16'd0,      12'hFFF, 0, 0, 0};
        tbl[5]  = '{16'(H+3),   16'd3,   0, 0, 3'd0, 16'd0,      12'h000, 0, 0, 0};
        tbl[6]  = '{16'(H-1),   16'd3,   0, 0, 3'd0, 16'd0,      12'h000, 0, 0, 0};
        tbl[7]  = '{16'(H),     16'd3,   1, 0, 3'd0, 16'd0,      12'hFFF, 0, 0, 0};
        tbl[8]  = '{16'(H+100), 16'd479, 1, 0, 3'd0, 16'd0,      12'h000, 0, 0, 0};
        tbl[9]  = '{16'd0,      16'd480, 0, 1, 3'd2, 16'd40,     12'h000, 1, 0, 0};
        tbl[10] = '{16'd0,      16'd481, 0, 0, 3'd0, 16'd0,      12'h000, 0, 0, 0};
        tbl[11] = '{16'(H+40),  16'd50,  1, 0, 3'd0, 16'd0,      12'hFFF, 0, 0, 0};
        tbl[12] = '{16'(H+100), 16'd50,  1, 0, 3'd0, 16'd0,      12'h000, 0, 0, 0};
        tbl[13] = '{16'(H+40),  16'd50,  1, 1, 3'd4, 16'h0A5C,   12'hFFF, 0, 0, 0};
        tbl[14] = '{16'(H+40),  16'd50,  1, 1, 3'd6, 16'd0,      12'hFFF, 0, 0, 0};
        tbl[15] = '{16'd0,      16'd480, 0, 0, 3'd0, 16'd0,      12'h000, 1, 0, 0};
        tbl[16] = '{16'(H+40),  16'd50,  1, 0, 3'd0, 16'd0,      12'hA5C, 0, 0, 0};
        tbl[17] = '{16'(H+20),  16'd10,  1, 0, 3'd0, 16'd0,      12'hA5C, 0, 0, 0};

        // Reset state before any clock edge
        rst = 1'b1;
        set_in(16'd0, 16'd0, 1'b0, 1'b0, 3'd0, 16'd0);
        model_reset();
        #5;
        check("reset_rgb", 32'({bus.r_out, bus.g_out, bus.b_out}), 32'h0);
        check("reset_frame_done", 32'(bus.frame_done), 32'h0);
        check("reset_coll", 32'({bus.coll_l, bus.coll_r}), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed table: commit timing, blank, write-through, ignored address, fg write
        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].hc, tbl[i].vc, tbl[i].bl, tbl[i].we, tbl[i].wa, tbl[i].wd);
            step($sformatf("row%0d", i));
            check($sformatf("row%0d_tbl_rgb", i),
                  32'({bus.r_out, bus.g_out, bus.b_out}), 32'(tbl[i].rgb));
            check($sformatf("row%0d_tbl_fd", i), 32'(bus.frame_done), 32'(tbl[i].fd));
            check($sformatf("row%0d_tbl_coll", i),
                  32'({bus.coll_l, bus.coll_r}), 32'({tbl[i].cl, tbl[i].cr}));
        end

        // Left collision reported after the frame, then cleared once the ball moves away
        wr(3'd0, 16'd100);
        wr(3'd2, 16'd20);
        wr(3'd3, 16'd120);
        commit_frame();
        pixel(20, 120);
        set_in(16'd0, 16'd480, 1'b0, 1'b0, 3'd0, 16'd0);
        step("coll_commit");
        check("coll_l_set", 32'(bus.coll_l), 32'h1);
        check("coll_r_clear", 32'(bus.coll_r), 32'h0);
        set_in(16'd0, 16'd481, 1'b0, 1'b0, 3'd0, 16'd0);
        step("vblank");
        wr(3'd2, 16'd300);
        commit_frame();
        pixel(20, 120);
        commit_frame();
        check("coll_l_after_move", 32'(bus.coll_l), 32'h0);

        // Async reset mid-line while rgb and coll_l are non-zero
        wr(3'd2, 16'd20);
        commit_frame();
        pixel(20, 120);
        commit_frame();
        pixel(18, 110);
        check("pre_reset_rgb_lit", 32'({bus.r_out, bus.g_out, bus.b_out} != 12'h0), 32'h1);
        #4 rst = 1'b1;
        #1;
        check("async_reset_rgb", 32'({bus.r_out, bus.g_out, bus.b_out}), 32'h0);
        check("async_reset_coll", 32'({bus.coll_l, bus.coll_r}), 32'h0);
        check("async_reset_fd", 32'(bus.frame_done), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Centre net column, objects moved off it
        wr(3'd0, 16'd400);
        wr(3'd1, 16'd400);
        wr(3'd2, 16'd400);
        wr(3'd3, 16'd400);
        commit_frame();
        for (int v = 0; v < 16; v++) begin
            pixel(310, v);
`ifdef PONG_NET_EN
            check($sformatf("net_v%0d", v), 32'({bus.r_out, bus.g_out, bus.b_out}),
                  (v < 8) ? 32'hFFF : 32'h0);
`else
            check($sformatf("net_v%0d", v), 32'({bus.r_out, bus.g_out, bus.b_out}), 32'h0);
`endif
        end

        // Random traffic biased towards objects and paddle-adjacent ball positions
        for (int n = 0; n < 3000; n++) begin
            int r, obj, bx, by, bw, bh;
            logic [15:0] hc, vc, wd;
            logic bl, we;
            logic [2:0] wa;
            r = int'($urandom_range(0, 99));
            bl = ($urandom_range(0, 7) != 0);
            if (r < 10) begin
                vc = 16'(480 + $urandom_range(0, 44));
                bl = 1'b0;
                hc = 16'($urandom_range(0, 799));
            end else if (r < 55) begin
                obj = int'($urandom_range(0, 2));
                bx = (obj == 0) ? int'(m_act[2]) : (obj == 1) ? 16 : 596;
                by = (obj == 0) ? int'(m_act[3]) : int'(m_act[obj - 1]);
                bw = 8;
                bh = (obj == 0) ? 8 : 64;
                hc = 16'(H + bx + int'($urandom_range(0, bw + 1)) - 1);
                vc = 16'(by + int'($urandom_range(0, bh + 1)) - 1);
            end else begin
                hc = 16'(H + int'($urandom_range(0, 619)));
                vc = 16'($urandom_range(0, 479));
            end
            we = ($urandom_range(0, 99) < 15);
            wa = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: wd = 16'hFFF0 + 16'($urandom_range(0, 15));
                1: wd = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(9, 23))
                                                    : 16'($urandom_range(589, 603));
                default: wd = 16'($urandom_range(0, 479));
            endcase
            if (wa == 3'd4) wd = 16'($urandom);
            set_in(hc, vc, bl, we, wa, wd);
            step($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
